// File: rtl/disp_scan_out.sv
// Display scan-out: raster timing, frame-buffer read enables and a two-stage output pipeline
// that keeps pixel, DE and syncs aligned with the buffer's one-clock read latency.
module disp_scan_out #(
    parameter int unsigned DATA_WIDTH = 24,
    parameter int unsigned CNT_WIDTH  = 12,
    parameter int unsigned H_ACTIVE   = 8,
    parameter int unsigned H_FP       = 2,
    parameter int unsigned H_SYNC     = 2,
    parameter int unsigned H_BP       = 2,
    parameter int unsigned V_ACTIVE   = 1,
    parameter int unsigned V_FP       = 1,
    parameter int unsigned V_SYNC     = 1,
    parameter int unsigned V_BP       = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  en,
    input  logic                  buf_rdy,
    input  logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_en_n,
    output logic [DATA_WIDTH-1:0] pix_data,
    output logic                  de,
    output logic                  hsync,
    output logic                  vsync,
    output logic                  frame_done,
    output logic                  underflow
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [CNT_WIDTH-1:0] HActEnd = CNT_WIDTH'(H_ACTIVE);
    localparam logic [CNT_WIDTH-1:0] HsBeg   = CNT_WIDTH'(H_ACTIVE + H_FP);
    localparam logic [CNT_WIDTH-1:0] HsEnd   = CNT_WIDTH'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CNT_WIDTH-1:0] HLast   = CNT_WIDTH'(H_TOTAL - 1);
    localparam logic [CNT_WIDTH-1:0] VActEnd = CNT_WIDTH'(V_ACTIVE);
    localparam logic [CNT_WIDTH-1:0] VsBeg   = CNT_WIDTH'(V_ACTIVE + V_FP);
    localparam logic [CNT_WIDTH-1:0] VsEnd   = CNT_WIDTH'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [CNT_WIDTH-1:0] VLast   = CNT_WIDTH'(V_TOTAL - 1);

    typedef enum logic [0:0] {StIdle, StScan} state_e;

    state_e                 state_q, state_d;
    logic [CNT_WIDTH-1:0]   h_cnt_q, h_cnt_d;
    logic [CNT_WIDTH-1:0]   v_cnt_q, v_cnt_d;
    logic                   frame_ok_q, frame_ok;
    logic                   scan, at_origin, at_last;
    logic                   act_s0, hs_s0, vs_s0, last_s0;
    logic                   act_q1, ok_q1, hs_q1, vs_q1, last_q1;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: if (en) state_d = StScan;
            StScan: if (at_last && !en) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Stage-0 decode and the combinational read enable
    always_comb begin
        scan      = (state_q == StScan);
        at_origin = (h_cnt_q == '0) && (v_cnt_q == '0);
        at_last   = (h_cnt_q == HLast) && (v_cnt_q == VLast);
        // buf_rdy is taken live at (0,0) so the first pixel's read is not lost
        frame_ok  = at_origin ? buf_rdy : frame_ok_q;
        act_s0    = scan && (h_cnt_q < HActEnd) && (v_cnt_q < VActEnd);
        hs_s0     = scan && (h_cnt_q >= HsBeg) && (h_cnt_q < HsEnd);
        vs_s0     = scan && (v_cnt_q >= VsBeg) && (v_cnt_q < VsEnd);
        last_s0   = scan && at_last;
        rd_en_n   = !(act_s0 && frame_ok);
    end

    always_comb begin
        h_cnt_d = '0;
        v_cnt_d = '0;
        if (scan && !at_last) begin
            if (h_cnt_q == HLast) begin
                v_cnt_d = v_cnt_q + CNT_WIDTH'(1);
            end else begin
                h_cnt_d = h_cnt_q + CNT_WIDTH'(1);
                v_cnt_d = v_cnt_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            h_cnt_q    <= '0;
            v_cnt_q    <= '0;
            frame_ok_q <= 1'b0;
            underflow  <= 1'b0;
        end else begin
            h_cnt_q    <= h_cnt_d;
            v_cnt_q    <= v_cnt_d;
            frame_ok_q <= scan && frame_ok;
            if (scan && at_origin && !buf_rdy) underflow <= 1'b1;
        end
    end

    // Stage 1 tracks the buffer read latency; stage 2 is the aligned output register
    always_ff @(posedge clk) begin
        if (reset) begin
            act_q1     <= 1'b0;
            ok_q1      <= 1'b0;
            hs_q1      <= 1'b0;
            vs_q1      <= 1'b0;
            last_q1    <= 1'b0;
            de         <= 1'b0;
            pix_data   <= '0;
            hsync      <= 1'b0;
            vsync      <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            act_q1     <= act_s0;
            ok_q1      <= scan && frame_ok;
            hs_q1      <= hs_s0;
            vs_q1      <= vs_s0;
            last_q1    <= last_s0;
            de         <= act_q1 && ok_q1;
            pix_data   <= (act_q1 && ok_q1) ? rd_data : '0;
            hsync      <= hs_q1;
            vsync      <= vs_q1;
            frame_done <= last_q1;
        end
    end

endmodule

// File: tb/tb_disp_scan_out.sv
// Directed bench for disp_scan_out: a cycle table for reset and the first line, then
// whole-frame sequences for underflow, stop, mid-frame reset and back-to-back frames.
module tb_disp_scan_out;

    localparam int DW = 24;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          en = 1'b1;
    logic          buf_rdy = 1'b1;
    logic [DW-1:0] rd_data = '0;
    logic          rd_en_n;
    logic [DW-1:0] pix_data;
    logic          de, hsync, vsync, frame_done, underflow;

    disp_scan_out dut (
        .clk        (clk),
        .reset      (reset),
        .en         (en),
        .buf_rdy    (buf_rdy),
        .rd_data    (rd_data),
        .rd_en_n    (rd_en_n),
        .pix_data   (pix_data),
        .de         (de),
        .hsync      (hsync),
        .vsync      (vsync),
        .frame_done (frame_done),
        .underflow  (underflow)
    );

    always #5 clk = ~clk;

    // Frame buffer model: returns 1, 2, 3, ... in read order, one clock after each read
    int fb_next = 1;
    always @(posedge clk) begin
        if (rd_en_n === 1'b0) begin
            rd_data <= DW'(fb_next);
            fb_next <= fb_next + 1;
        end
    end

    int checks = 0;
    int errors = 0;
    int n_rd, n_de, n_hs, n_vs, n_fd, fd_off, cur_off;
    int tot_rd;
    int exp_pix;
    bit chk_pix = 1'b0;

    typedef struct {
        logic          rst;
        logic          rd_n;
        logic          de;
        logic [DW-1:0] pix;
        logic          hs;
        logic          vs;
        logic          fd;
        logic          uf;
    } vec_t;

    vec_t tbl[18];

    function automatic vec_t mk(input logic rst, input logic rd_n, input logic d,
                                input logic [DW-1:0] pix, input logic hs);
        vec_t v;
        v.rst = rst; v.rd_n = rd_n; v.de = d; v.pix = pix; v.hs = hs;
        v.vs = 1'b0; v.fd = 1'b0; v.uf = 1'b0;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic clear_counts();
        n_rd = 0; n_de = 0; n_hs = 0; n_vs = 0; n_fd = 0; fd_off = -1; cur_off = 0;
    endtask

    // Apply inputs on the falling edge, then sample outputs just after
    task automatic step(input logic r, input logic e, input logic b);
        @(negedge clk);
        reset = r; en = e; buf_rdy = b;
        #1;
        if (rd_en_n === 1'b0) n_rd++;
        if (de === 1'b1) n_de++;
        if (hsync === 1'b1) n_hs++;
        if (vsync === 1'b1) n_vs++;
        if (frame_done === 1'b1) begin n_fd++; fd_off = cur_off; end
        if (chk_pix) begin
            if (de === 1'b1) begin
                chk("pix_stream", 32'(pix_data), 32'(exp_pix));
                exp_pix++;
            end else begin
                chk("pix_blank", 32'(pix_data), 32'd0);
            end
        end
        cur_off++;
    endtask

    // One 56-clock window starting at counter (0,0)
    task automatic run_frame(input logic rdy0, input int en_drop_at);
        clear_counts();
        for (int off = 0; off < 56; off++) begin
            step(1'b0, (off < en_drop_at), (off < 3) ? rdy0 : 1'b1);
        end
    endtask

    task automatic chk_counts(input string tag, input int rd, input int d, input int hs,
                              input int vs, input int fd, input int fdo);
        chk({tag, " reads"}, n_rd, rd);
        chk({tag, " de_cnt"}, n_de, d);
        chk({tag, " hs_cnt"}, n_hs, hs);
        chk({tag, " vs_cnt"}, n_vs, vs);
        chk({tag, " fd_cnt"}, n_fd, fd);
        chk({tag, " fd_pos"}, fd_off, fdo);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish, got running expected done");
        $fatal(1);
    end

    initial begin
        //             rst   rd_n  de    pix  hs
        tbl[0]  = mk(1'b1, 1'b1, 1'b0, 24'd0, 1'b0);
        tbl[1]  = mk(1'b1, 1'b1, 1'b0, 24'd0, 1'b0);
        tbl[2]  = mk(1'b1, 1'b1, 1'b0, 24'd0, 1'b0);
        tbl[3]  = mk(1'b0, 1'b1, 1'b0, 24'd0, 1'b0);  // edge after this samples en
        tbl[4]  = mk(1'b0, 1'b0, 1'b0, 24'd0, 1'b0);  // (0,0)
        tbl[5]  = mk(1'b0, 1'b0, 1'b0, 24'd0, 1'b0);
        tbl[6]  = mk(1'b0, 1'b0, 1'b1, 24'd1, 1'b0);
        tbl[7]  = mk(1'b0, 1'b0, 1'b1, 24'd2, 1'b0);
        tbl[8]  = mk(1'b0, 1'b0, 1'b1, 24'd3, 1'b0);
        tbl[9]  = mk(1'b0, 1'b0, 1'b1, 24'd4, 1'b0);
        tbl[10] = mk(1'b0, 1'b0, 1'b1, 24'd5, 1'b0);
        tbl[11] = mk(1'b0, 1'b0, 1'b1, 24'd6, 1'b0);  // h=7, last read
        tbl[12] = mk(1'b0, 1'b1, 1'b1, 24'd7, 1'b0);
        tbl[13] = mk(1'b0, 1'b1, 1'b1, 24'd8, 1'b0);
        tbl[14] = mk(1'b0, 1'b1, 1'b0, 24'd0, 1'b0);
        tbl[15] = mk(1'b0, 1'b1, 1'b0, 24'd0, 1'b0);
        tbl[16] = mk(1'b0, 1'b1, 1'b0, 24'd0, 1'b1);  // h=10 sync output
        tbl[17] = mk(1'b0, 1'b1, 1'b0, 24'd0, 1'b1);

        for (int i = 0; i < 18; i++) begin
            step(tbl[i].rst, 1'b1, 1'b1);
            chk($sformatf("row%0d rd_en_n", i), 32'(rd_en_n), 32'(tbl[i].rd_n));
            chk($sformatf("row%0d de", i), 32'(de), 32'(tbl[i].de));
            chk($sformatf("row%0d pix", i), 32'(pix_data), 32'(tbl[i].pix));
            chk($sformatf("row%0d hsync", i), 32'(hsync), 32'(tbl[i].hs));
            chk($sformatf("row%0d vsync", i), 32'(vsync), 32'(tbl[i].vs));
            chk($sformatf("row%0d frame_done", i), 32'(frame_done), 32'(tbl[i].fd));
            chk($sformatf("row%0d underflow", i), 32'(underflow), 32'(tbl[i].uf));
        end

        // Rest of frame 1: lines 1..3 only carry syncs
        exp_pix = 9;
        chk_pix = 1'b1;
        clear_counts();
        for (int i = 0; i < 42; i++) step(1'b0, 1'b1, 1'b1);
        chk_counts("f1_tail", 0, 0, 6, 14, 0, -1);

        // Frame 2: buffer not ready at (0,0), ready from h=3
        run_frame(1'b0, 99);
        chk_counts("underflow_frame", 0, 0, 8, 14, 1, 1);
        chk("underflow_set", 32'(underflow), 32'd1);

        // Frame 3: good frame after a blanked one, underflow stays sticky
        run_frame(1'b1, 99);
        chk_counts("good_after_uf", 8, 8, 8, 14, 1, 1);
        chk("underflow_sticky", 32'(underflow), 32'd1);

        // Frame 4: en dropped at h=5, v=0; the frame still completes
        run_frame(1'b1, 5);
        chk_counts("stop_frame", 8, 8, 8, 14, 1, 1);
        clear_counts();
        for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 1'b1);
        chk_counts("idle_after_stop", 0, 0, 0, 0, 1, 1);
        chk("idle rd_en_n", 32'(rd_en_n), 32'd1);
        chk("idle de", 32'(de), 32'd0);
        chk("idle hsync", 32'(hsync), 32'd0);
        chk("idle vsync", 32'(vsync), 32'd0);
        chk("idle frame_done", 32'(frame_done), 32'd0);

        // Reset asserted on the 4th active pixel
        chk_pix = 1'b0;
        step(1'b0, 1'b1, 1'b1);
        chk("restart idle rd_en_n", 32'(rd_en_n), 32'd1);
        step(1'b0, 1'b1, 1'b1);
        chk("restart origin rd_en_n", 32'(rd_en_n), 32'd0);
        step(1'b0, 1'b1, 1'b1);
        step(1'b0, 1'b1, 1'b1);
        step(1'b1, 1'b1, 1'b1);
        chk("pre_reset de", 32'(de), 32'd1);
        step(1'b0, 1'b1, 1'b1);
        chk("post_reset rd_en_n", 32'(rd_en_n), 32'd1);
        chk("post_reset de", 32'(de), 32'd0);
        chk("post_reset pix", 32'(pix_data), 32'd0);
        chk("post_reset underflow", 32'(underflow), 32'd0);
        exp_pix = fb_next;
        chk_pix = 1'b1;

        // Back-to-back: three frames from a fresh (0,0)
        tot_rd = 0;
        run_frame(1'b1, 99);
        chk_counts("b2b_f1", 8, 8, 8, 14, 0, -1);
        tot_rd += n_rd;
        run_frame(1'b1, 99);
        chk_counts("b2b_f2", 8, 8, 8, 14, 1, 1);
        tot_rd += n_rd;
        run_frame(1'b1, 99);
        chk_counts("b2b_f3", 8, 8, 8, 14, 1, 1);
        tot_rd += n_rd;
        chk("b2b total reads", 32'(tot_rd), 32'd24);
        clear_counts();
        step(1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b1);
        chk("b2b third frame_done pos", 32'(fd_off), 32'd1);
        chk("b2b underflow clear", 32'(underflow), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/disp_scan_out.md
# disp_scan_out

Display scan-out stage that sits directly downstream of the frame buffer. It generates raster timing (horizontal/vertical counters, hsync, vsync, data-enable) and issues per-pixel read enables to the frame buffer during the active area. It then re-times the returned pixel data so that pixel, DE and syncs leave the block aligned on the same clock edge. Frames whose buffer is not ready at frame start are blanked, with syncs preserved, and an underflow flag is latched.

## Interface
- DATA_WIDTH, 24, pixel width; matches frame buffer data width
- CNT_WIDTH, 12, width of h_cnt/v_cnt
- H_ACTIVE / H_FP / H_SYNC / H_BP, 8 / 2 / 2 / 2, horizontal active, front porch, sync and back porch in clocks
- V_ACTIVE / V_FP / V_SYNC / V_BP, 1 / 1 / 1 / 1, vertical equivalents in lines
- H_TOTAL = sum of H_*; V_TOTAL = sum of V_*; defaults 14 and 4, so one frame is 56 clocks with 8 active pixels

Ports:
- clk  in  1  single clock; all logic on posedge
- reset  in  1  synchronous, active-high
- en  in  1  run request; level-sensitive
- buf_rdy  in  1  frame buffer holds a complete frame (the buffer's mem_rdy)
- rd_data  in  DATA_WIDTH  frame buffer read data; valid 1 clock after a read enable
- rd_en_n  out  1  active-low read enable to frame buffer; one pixel consumed per low cycle
- pix_data  out  DATA_WIDTH  output pixel; zero whenever de=0
- de  out  1  data enable, active-high
- hsync  out  1  active-high
- vsync  out  1  active-high
- frame_done  out  1  one-clock pulse at the last counter position of each scanned frame
- underflow  out  1  sticky; set when a frame is blanked for lack of buf_rdy; cleared only by reset

## Operation
- FSM states:
  - IDLE: h_cnt=v_cnt=0 held; all outputs at reset values. IDLE→SCAN at the clock edge where en=1.
  - SCAN: h_cnt counts 0..H_TOTAL-1 and wraps to 0 while incrementing v_cnt; v_cnt wraps at V_TOTAL-1.
  - At the position (H_TOTAL-1, V_TOTAL-1): if en=0, go to IDLE; otherwise stay in SCAN with counters returning to (0,0).
  - Deasserting en mid-frame always completes the current frame before returning to IDLE.
- Frame gating: at every counter position (0,0) in SCAN, buf_rdy is sampled into frame_ok, which is held for the whole frame.
  - frame_ok=0: rd_en_n stays 1 and de stays 0 for that frame, but syncs still run.
  - frame_ok=0 also sets underflow.
- Stage-0 decode from the counters:
  - act = (h_cnt < H_ACTIVE) && (v_cnt < V_ACTIVE)
  - hs = H_ACTIVE+H_FP ≤ h_cnt < H_ACTIVE+H_FP+H_SYNC
  - vs = V_ACTIVE+V_FP ≤ v_cnt < V_ACTIVE+V_FP+V_SYNC
- rd_en_n = !(SCAN && act && frame_ok), decoded combinationally from stage-0 registers, so the buffer sees it in the same cycle.
- act, hs, vs and frame_ok pass through a 1-deep delay register (stage 1), in step with the buffer's 1-clock read latency.
- Stage 2: output registers capture stage 1 and rd_data.
  - de = act_d & frame_ok_d
  - pix_data = de ? rd_data : 0
  - hsync = hs_d, vsync = vs_d
- frame_done is registered and asserted for the one cycle in which the frame's last counter position is presented.
  - It is set for blanked frames too.

## Timing
- Reset values, applied at the next edge and overriding every state including mid-frame:
  - state=IDLE, counters 0, delay registers 0
  - rd_en_n=1, de=0, pix_data=0, hsync=0, vsync=0, frame_done=0, underflow=0
- Edge k samples en=1 in IDLE; cycle k+1 is counter (0,0) and rd_en_n=0 (if buf_rdy was 1 at k+1).
- Pixel-path latency: counter position → de/pix_data/hsync/vsync is exactly 2 clocks; all four stay mutually aligned.
- Active pixels per frame = H_ACTIVE×V_ACTIVE read enables, with no gaps inside a line.
- Counter arithmetic is unsigned CNT_WIDTH bits; parameters must satisfy H_TOTAL, V_TOTAL ≤ 2^CNT_WIDTH.
- If buf_rdy toggles mid-frame, there is no effect until the next (0,0).
- On en=0 return to IDLE, pipeline stages drain with blank values (de=0, syncs 0).

## Test plan
- Reset: hold reset 3 clocks with en=1 and buf_rdy=1 → every output at its reset value; after release, rd_en_n first goes low exactly 2 clocks later (edge that samples en, then the (0,0) cycle).
- Normal frame: en=1, buf_rdy=1, rd_data = 1..8 returned in read order → rd_en_n low 8 consecutive clocks; de high 8 clocks starting 2 clocks after the first rd_en_n low; pix_data=1..8; hsync high at h=10,11 (+2 latency); vsync high on line 2 only; frame_done once per 56 clocks.
- Underflow: buf_rdy=0 at (0,0) and 1 at h=3 → no rd_en_n low, de=0 for the whole frame, syncs unchanged, underflow=1 and still 1 after later good frames.
- Stop mid-frame: drop en at h=5,v=0 → frame runs to (13,3), frame_done pulses, then IDLE with all outputs 0 and no further reads.
- Reset mid-active: assert reset at the 4th active pixel → next edge rd_en_n=1, de=0, pix_data=0; after release, scanning restarts at (0,0).
- Back-to-back: en held for 3 frames → exactly 24 read enables, 3 frame_done pulses 56 clocks apart, no timing slip.
